opcode_class_encoder: RTL and testbench

Buffered encoder that turns a 3-bit opcode class plus a 2-bit variant into the canonical 8-bit opcode byte. It is the inverse of the opcode-class decoder: every byte it emits decodes back to the class it was given. It sits between the instruction-generation logic and the byte stream. Input and output use valid/ready handshakes, with a small FIFO in between.

---
 rtl/opcode_class_encoder.sv | 122 ++++++++++++
 tb/tb_opcode_class_encoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_class_encoder.sv
// Buffered class/variant -> canonical opcode byte encoder with a small FIFO.
// Optional round-trip self-check on pop: define OPENC_SELFCHECK_EN.
module opcode_class_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_class,
    input  logic [1:0]               in_var,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         rej_cnt,
    output logic                     chk_err
);

    localparam int AW = $clog2(DEPTH);
`ifdef OPENC_SELFCHECK_EN
    localparam int EW = 11;
`else
    localparam int EW = 8;
`endif
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]      FULL_XOR = {1'b1, {AW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [7:0]    last_byte, enc_byte;
    logic [EW-1:0] head, entry;
    logic          full, empty, accept, push, pop, is_drop, is_rej;

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and in_ready ignores out_ready.
    assign full      = (wr_ptr ^ rd_ptr) == FULL_XOR;
    assign empty     = wr_ptr == rd_ptr;
    assign in_ready  = !full & reset_n;
    assign accept    = in_valid & in_ready;
    assign is_drop   = in_class == 3'b000;
    assign is_rej    = !in_class[2] && !is_drop;
    assign push      = accept & in_class[2];
    assign out_valid = !empty;
    assign pop       = out_valid & out_ready;
    assign occupancy = wr_ptr - rd_ptr;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_byte  = empty ? last_byte : head[7:0];

    always_comb begin
        enc_byte = 8'h00;
        case (in_class)
            3'b100: enc_byte = in_var[0] ? 8'hBC : 8'hB0;
            3'b101: enc_byte = in_var[0] ? 8'hB2 : 8'hB4;
            3'b110: enc_byte = in_var[0] ? 8'h91 : 8'h90;
            3'b111: begin
                case (in_var)
                    2'd0:    enc_byte = 8'h98;
                    2'd1:    enc_byte = 8'h9A;
                    2'd2:    enc_byte = 8'h9E;
                    default: enc_byte = 8'h9F;
                endcase
            end
            default: enc_byte = 8'h00;
        endcase
    end

`ifdef OPENC_SELFCHECK_EN
    assign entry = {in_class, enc_byte};
`else
    assign entry = enc_byte;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_byte <= 8'h00;
            drop_cnt  <= '0;
            rej_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                last_byte <= head[7:0];
            end
            if (accept && is_drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
            if (accept && is_rej && rej_cnt != '1) rej_cnt <= rej_cnt + CNT_ONE;
        end
    end

`ifdef OPENC_SELFCHECK_EN
    logic [2:0] dec_class;

    // Canonical decode of the byte leaving the FIFO, independent of the encoder.
    always_comb begin
        dec_class = 3'b000;
        case (head[7:0])
            8'hB0, 8'hBC:                             dec_class = 3'b100;
            8'hB4, 8'hB2:                             dec_class = 3'b101;
            8'h90, 8'h91:                             dec_class = 3'b110;
            8'h98, 8'h99, 8'h9A, 8'h9B, 8'h9E, 8'h9F: dec_class = 3'b111;
            default:                                  dec_class = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chk_err <= 1'b0;
        else if (pop && dec_class != head[10:8]) chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_class_encoder.sv
// Scoreboard bench for opcode_class_encoder: random and directed stimulus,
// expected bytes queued at accept, popped by an independent output monitor.
module tb_opcode_class_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [2:0]             in_class = 3'd0;
    logic [1:0]             in_var = 2'd0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [7:0]             out_byte;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0]       drop_cnt;
    logic [CNT_W-1:0]       rej_cnt;
    logic                   chk_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_drop = 0;
    int exp_rej = 0;
    logic rnd_ready = 1'b0;

    // Canonical byte table indexed by {class[1:0], var} for classes 100..111.
    logic [7:0] enc_tab [16] = '{
        8'hB0, 8'hBC, 8'hB0, 8'hBC,
        8'hB4, 8'hB2, 8'hB4, 8'hB2,
        8'h90, 8'h91, 8'h90, 8'h91,
        8'h98, 8'h9A, 8'h9E, 8'h9F
    };

    opcode_class_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_var(in_var),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .occupancy(occupancy), .drop_cnt(drop_cnt), .rej_cnt(rej_cnt),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour of one accepted input.
    task automatic model_accept(input int c, input int v);
        if (c >= 4) exp_q.push_back(enc_tab[(c - 4) * 4 + v]);
        else if (c == 0) exp_drop = (exp_drop + 1 > 255) ? 255 : exp_drop + 1;
        else exp_rej = (exp_rej + 1 > 255) ? 255 : exp_rej + 1;
    endtask

    // Offer one input; returns after the accepting edge (+1).
    task automatic send(input int c, input int v);
        int n;
        in_class = 3'(c);
        in_var   = 2'(v);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 100 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(c, v);
        #1;
        in_valid = 1'b0;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (occupancy != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_occupancy", int'(occupancy), 0);
    endtask

    // Output monitor: every presented byte must equal the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got 0x%0h with no expected byte queued", out_byte);
            end else begin
                check("out_byte", int'(out_byte), int'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        // Reset state
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_byte", int'(out_byte), 0);
        check("rst_occupancy", int'(occupancy), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_rej_cnt", int'(rej_cnt), 0);
        check("rst_chk_err", int'(chk_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single accept, latency and retained byte
        out_ready = 1'b1;
        check("idle_out_valid", int'(out_valid), 0);
        send(7, 2);
        check("lat_out_valid", int'(out_valid), 1);
        check("lat_out_byte", int'(out_byte), 8'h9E);
        @(posedge clk);
        #1;
        check("lat_occupancy", int'(occupancy), 0);
        check("retain_out_byte", int'(out_byte), 8'h9E);

        // Fill to full with the sink stalled
        out_ready = 1'b0;
        send(4, 1);
        send(5, 0);
        send(6, 1);
        send(7, 3);
        check("full_in_ready", int'(in_ready), 0);
        check("full_occupancy", int'(occupancy), DEPTH);

        // One cycle of offer + pop at full: pop only
        in_class = 3'd4;
        in_var   = 2'd0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("afterpop_in_ready", int'(in_ready), 1);
        check("afterpop_occupancy", int'(occupancy), 3);

        // Drain one per cycle
        out_ready = 1'b1;
        n = 0;
        while (occupancy != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_cycles", n, 3);
        check("drain_sb_empty", exp_q.size(), 0);

        // Counter saturation
        for (int i = 0; i < 300; i++) send(0, int'($urandom_range(0, 3)));
        for (int i = 0; i < 2; i++) send(2, int'($urandom_range(0, 3)));
        check("drop_cnt_sat", int'(drop_cnt), exp_drop);
        check("rej_cnt", int'(rej_cnt), exp_rej);

        // Random traffic with random sink backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        rnd_ready = 1'b0;
        drain();
        @(posedge clk);
        #1;
        check("rnd_sb_empty", exp_q.size(), 0);
        check("rnd_drop_cnt", int'(drop_cnt), exp_drop);
        check("rnd_rej_cnt", int'(rej_cnt), exp_rej);

        // Reset mid-stream
        out_ready = 1'b0;
        send(4, 0);
        send(5, 1);
        send(6, 0);
        check("pre_rst_out_valid", int'(out_valid), 1);
        check("pre_rst_occupancy", int'(occupancy), 3);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_byte", int'(out_byte), 0);
        check("mid_rst_occupancy", int'(occupancy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_drop_cnt", int'(drop_cnt), 0);
        exp_q.delete();
        exp_drop = 0;
        exp_rej = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_out_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        send(7, 0);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_sb_empty", exp_q.size(), 0);
        check("post_rst_occupancy", int'(occupancy), 0);
        check("post_rst_out_byte", int'(out_byte), 8'h98);

`ifdef OPENC_SELFCHECK_EN
        // Round-trip self-check over every legal pair, then a corrupted entry
        for (int c = 4; c < 8; c++)
            for (int v = 0; v < 4; v++) send(c, v);
        drain();
        check("sc_clean_chk_err", int'(chk_err), 0);
        out_ready = 1'b0;
        send(6, 0);
        @(negedge clk);
        #1;
        dut.mem[dut.rd_ptr[$clog2(DEPTH)-1:0]][7:0] = 8'h55;
        exp_q[0] = 8'h55;
        check("sc_pre_chk_err", int'(chk_err), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sc_chk_err_set", int'(chk_err), 1);
        repeat (3) @(posedge clk);
        #1;
        check("sc_chk_err_sticky", int'(chk_err), 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
